// File: rtl/ddc_multi_pkg.sv
// Shared constants, field offsets and helpers for the multi-lane DDC combiner.
// Imported by the adder tree and the combiner top.
package ddc_multi_pkg;

   localparam int PH_LAT = 2;

   localparam int POFF_LSB = 32;
   localparam int PINC_LSB = 0;

   localparam int I_LSB = 0;
   localparam int Q_LSB = 32;

   localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN = 32'h8000_0000;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] i;
   } ddc_res_t;

   function automatic int log2n(input int n);
      int r;
      r = 0;
      for (int b = 0; b < 31; b++)
         if ((1 << b) < n) r = b + 1;
      return r;
   endfunction

   // k*x built from shifted copies of x, k < 32
   function automatic logic [31:0] mul_k(input logic [31:0] x,
                                         input int k);
      logic [31:0] acc;
      acc = '0;
      for (int b = 0; b < 5; b++)
         if (k[b]) acc = acc + (x << b);
      return acc;
   endfunction

endpackage

// File: rtl/ddc_sum_tree.sv
// Pipelined pairwise reduction of N_LANES signed samples.
// One register level per tree level, each level one bit wider.
module ddc_sum_tree
   import ddc_multi_pkg::*;
#(
   parameter int N_LANES = 8,
   parameter int IN_RES = 27,
   localparam int LOG2N = log2n(N_LANES),
   localparam int OUT_W = IN_RES + LOG2N
) (
   input  logic                      s_axis_aclk,
   input  logic                      s_axis_aresetn,
   input  logic                      tag_clr,
   input  logic                      in_valid,
   input  logic [N_LANES*IN_RES-1:0] in_data,
   output logic                      out_valid,
   output logic [OUT_W-1:0]          out_data
);

   logic [LOG2N-1:0] tag;

   for (genvar s = 1; s <= LOG2N; s++) begin : g_st
      localparam int W = IN_RES + s;
      localparam int M = N_LANES >> s;

      logic [2*M*(W-1)-1:0] src;
      logic [M*W-1:0]       q;

      if (s == 1) begin : g_src
         assign src = in_data;
      end else begin : g_src
         assign src = g_st[s-1].q;
      end

      // one adder level; each operand sign-extended by one bit
      always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
         if (!s_axis_aresetn) begin
            q <= '0;
         end else begin
            for (int j = 0; j < M; j++)
               q[j*W +: W] <=
                  {src[2*j*(W-1)+W-2], src[2*j*(W-1) +: W-1]} +
                  {src[(2*j+1)*(W-1)+W-2], src[(2*j+1)*(W-1) +: W-1]};
         end
      end
   end

   // valid tags ride alongside the data; tag_clr flushes the tree
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) tag <= '0;
      else if (tag_clr)    tag <= '0;
      else                 tag <= LOG2N'({tag, in_valid});
   end

   assign out_valid = tag[LOG2N-1];
   assign out_data  = g_st[LOG2N].q;

endmodule

// File: rtl/ddc_multi_combiner.sv
// Multi-lane DDC glue: lane phase words, I/Q reduction, decimating
// accumulator with saturation, and a 2-deep backpressured output.
module ddc_multi_combiner
   import ddc_multi_pkg::*;
#(
   parameter int N_LANES = 8,
   parameter int IN_RES = 27,
   parameter int DECIM_BITS = 8
) (
   input  logic                    s_axis_aclk,
   input  logic                    s_axis_aresetn,
   input  logic [63:0]             s_axis_phase_tdata,
   input  logic                    s_axis_phase_tvalid,
   input  logic                    resync,
   output logic [64*N_LANES-1:0]   m_axis_phase_tdata,
   output logic                    m_axis_phase_tvalid,
   output logic                    m_axis_resync,
   input  logic [64*N_LANES-1:0]   s_axis_lanes_tdata,
   input  logic                    s_axis_lanes_tvalid,
   input  logic [DECIM_BITS-1:0]   cfg_decim,
   input  logic                    clear_status,
   output logic [63:0]             m_axis_ddc_tdata,
   output logic                    m_axis_ddc_tvalid,
   input  logic                    m_axis_ddc_tready,
   output logic                    sat_flag,
   output logic                    drop_flag
);

   localparam int LOG2N = log2n(N_LANES);
   localparam int TW = IN_RES + LOG2N;
   localparam int AW = TW + DECIM_BITS;

   logic [31:0] pinc_in, poff_in;
   logic [31:0] kp [N_LANES];
   logic [31:0] poff1, pincn1, pincn2;
   logic [31:0] poff2 [N_LANES];
   logic [PH_LAT-1:0] pv_sr, rs_sr;

   assign pinc_in = s_axis_phase_tdata[PINC_LSB +: 32];
   assign poff_in = s_axis_phase_tdata[POFF_LSB +: 32];

   // stage 1: capture the command and form k*pinc per lane
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         for (int k = 0; k < N_LANES; k++) kp[k] <= '0;
         poff1  <= '0;
         pincn1 <= '0;
      end else if (s_axis_phase_tvalid) begin
         for (int k = 0; k < N_LANES; k++) kp[k] <= mul_k(pinc_in, k);
         poff1  <= poff_in;
         pincn1 <= pinc_in << LOG2N;
      end
   end

   // stage 2: per-lane start phase, wrapping modulo 2^32
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         for (int k = 0; k < N_LANES; k++) poff2[k] <= '0;
         pincn2 <= '0;
      end else begin
         for (int k = 0; k < N_LANES; k++) poff2[k] <= poff1 + kp[k];
         pincn2 <= pincn1;
      end
   end

   // strobe and resync delay lines matched to the phase pipeline
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         pv_sr <= '0;
         rs_sr <= '0;
      end else begin
         pv_sr <= PH_LAT'({pv_sr, s_axis_phase_tvalid});
         rs_sr <= PH_LAT'({rs_sr, resync});
      end
   end

   assign m_axis_phase_tvalid = pv_sr[PH_LAT-1];
   assign m_axis_resync       = rs_sr[PH_LAT-1];

   // pack lane phase words
   always_comb begin
      m_axis_phase_tdata = '0;
      for (int k = 0; k < N_LANES; k++)
         m_axis_phase_tdata[64*k +: 64] = {poff2[k], pincn2};
   end

   logic [N_LANES*IN_RES-1:0] i_bus, q_bus;
   logic unused_lane_bits;

   // split lanes into I and Q buses; spare lane bits are ignored
   always_comb begin
      i_bus = '0;
      q_bus = '0;
      unused_lane_bits = 1'b0;
      for (int k = 0; k < N_LANES; k++) begin
         i_bus[k*IN_RES +: IN_RES] =
            s_axis_lanes_tdata[64*k+I_LSB +: IN_RES];
         q_bus[k*IN_RES +: IN_RES] =
            s_axis_lanes_tdata[64*k+Q_LSB +: IN_RES];
         unused_lane_bits = unused_lane_bits
            ^ (^s_axis_lanes_tdata[64*k+I_LSB+IN_RES +: 32-IN_RES])
            ^ (^s_axis_lanes_tdata[64*k+Q_LSB+IN_RES +: 32-IN_RES]);
      end
   end

   logic          tv_i, tv_q, tv;
   logic [TW-1:0] t_i, t_q;

   ddc_sum_tree #(.N_LANES(N_LANES), .IN_RES(IN_RES)) u_tree_i (
      .s_axis_aclk   (s_axis_aclk),
      .s_axis_aresetn(s_axis_aresetn),
      .tag_clr       (resync),
      .in_valid      (s_axis_lanes_tvalid),
      .in_data       (i_bus),
      .out_valid     (tv_i),
      .out_data      (t_i)
   );

   ddc_sum_tree #(.N_LANES(N_LANES), .IN_RES(IN_RES)) u_tree_q (
      .s_axis_aclk   (s_axis_aclk),
      .s_axis_aresetn(s_axis_aresetn),
      .tag_clr       (resync),
      .in_valid      (s_axis_lanes_tvalid),
      .in_data       (q_bus),
      .out_valid     (tv_q),
      .out_data      (t_q)
   );

   assign tv = tv_i & tv_q;

   function automatic logic fits32(input logic [AW-1:0] v);
      return (&v[AW-1:31]) | (~|v[AW-1:31]);
   endfunction

   function automatic logic [31:0] sat32(input logic [AW-1:0] v);
      if (fits32(v)) return v[31:0];
      return v[AW-1] ? SAT_MIN : SAT_MAX;
   endfunction

   logic [AW-1:0]         acc_i, acc_q, sum_i, sum_q;
   logic [DECIM_BITS-1:0] cnt, d_act, d_cfg, d_eff;
   logic                  d_fresh, last, emit, sat_set;

   // d_fresh makes the first cycle out of reset pick up cfg_decim
   assign d_cfg = (cfg_decim == '0) ? DECIM_BITS'(1) : cfg_decim;
   assign d_eff = d_fresh ? d_cfg : d_act;
   assign last  = (cnt == d_eff - DECIM_BITS'(1));
   assign emit  = tv & ~resync & last;
   assign sum_i = acc_i + {{DECIM_BITS{t_i[TW-1]}}, t_i};
   assign sum_q = acc_q + {{DECIM_BITS{t_q[TW-1]}}, t_q};
   assign sat_set = emit & ~(fits32(sum_i) & fits32(sum_q));

   // frame accumulation; D is re-latched only at frame boundaries
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         acc_i   <= '0;
         acc_q   <= '0;
         cnt     <= '0;
         d_act   <= '0;
         d_fresh <= 1'b1;
      end else begin
         d_fresh <= 1'b0;
         d_act   <= d_eff;
         if (resync) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
            d_act <= d_cfg;
         end else if (tv) begin
            if (last) begin
               acc_i <= '0;
               acc_q <= '0;
               cnt   <= '0;
               d_act <= d_cfg;
            end else begin
               acc_i <= sum_i;
               acc_q <= sum_q;
               cnt   <= cnt + DECIM_BITS'(1);
            end
         end
      end
   end

   ddc_res_t res_q;
   logic     emit_q;

   // register the saturated result ahead of the FIFO
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         emit_q <= 1'b0;
         res_q  <= '0;
      end else begin
         emit_q <= emit;
         if (emit) begin
            res_q.i <= sat32(sum_i);
            res_q.q <= sat32(sum_q);
         end
      end
   end

   ddc_res_t   mem [2];
   logic       wr_ptr, rd_ptr, push, pop, full, drop;
   logic [1:0] f_cnt;

   assign pop  = m_axis_ddc_tvalid & m_axis_ddc_tready;
   assign full = (f_cnt == 2'd2);
   assign push = emit_q & (~full | pop);
   assign drop = emit_q & full & ~pop;

   // 2-entry first-word-fall-through output queue
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         f_cnt  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= res_q;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         f_cnt <= f_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   assign m_axis_ddc_tvalid = (f_cnt != 2'd0);
   assign m_axis_ddc_tdata  = mem[rd_ptr];

   // sticky status; a set in the clear cycle wins
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         sat_flag  <= 1'b0;
         drop_flag <= 1'b0;
      end else begin
         if (sat_set)           sat_flag <= 1'b1;
         else if (clear_status) sat_flag <= 1'b0;
         if (drop)              drop_flag <= 1'b1;
         else if (clear_status) drop_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ddc_multi_combiner.sv
// Directed self-checking bench for ddc_multi_combiner (N=8 lanes).
// Each task drives one scenario and checks it inline.
module tb_ddc_multi_combiner;

   logic           s_axis_aclk = 1'b0;
   logic           s_axis_aresetn;
   logic [63:0]    s_axis_phase_tdata;
   logic           s_axis_phase_tvalid;
   logic           resync;
   logic [511:0]   m_axis_phase_tdata;
   logic           m_axis_phase_tvalid;
   logic           m_axis_resync;
   logic [511:0]   s_axis_lanes_tdata;
   logic           s_axis_lanes_tvalid;
   logic [7:0]     cfg_decim;
   logic           clear_status;
   logic [63:0]    m_axis_ddc_tdata;
   logic           m_axis_ddc_tvalid;
   logic           m_axis_ddc_tready;
   logic           sat_flag;
   logic           drop_flag;

   int n_checks = 0;
   int n_fail = 0;

   always #5 s_axis_aclk = ~s_axis_aclk;

   ddc_multi_combiner dut (
      .s_axis_aclk        (s_axis_aclk),
      .s_axis_aresetn     (s_axis_aresetn),
      .s_axis_phase_tdata (s_axis_phase_tdata),
      .s_axis_phase_tvalid(s_axis_phase_tvalid),
      .resync             (resync),
      .m_axis_phase_tdata (m_axis_phase_tdata),
      .m_axis_phase_tvalid(m_axis_phase_tvalid),
      .m_axis_resync      (m_axis_resync),
      .s_axis_lanes_tdata (s_axis_lanes_tdata),
      .s_axis_lanes_tvalid(s_axis_lanes_tvalid),
      .cfg_decim          (cfg_decim),
      .clear_status       (clear_status),
      .m_axis_ddc_tdata   (m_axis_ddc_tdata),
      .m_axis_ddc_tvalid  (m_axis_ddc_tvalid),
      .m_axis_ddc_tready  (m_axis_ddc_tready),
      .sat_flag           (sat_flag),
      .drop_flag          (drop_flag)
   );

   task automatic tick();
      @(posedge s_axis_aclk);
      #1;
   endtask

   task automatic set_lanes(input logic [31:0] iv, input logic [31:0] qv);
      for (int k = 0; k < 8; k++) s_axis_lanes_tdata[64*k +: 64] = {qv, iv};
   endtask

   task automatic do_resync(input logic [7:0] d);
      s_axis_lanes_tvalid = 1'b0;
      cfg_decim = d;
      resync = 1'b1;
      tick();
      resync = 1'b0;
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_reset();
      s_axis_aresetn = 1'b0;
      s_axis_phase_tdata = '0;
      s_axis_phase_tvalid = 1'b0;
      resync = 1'b0;
      s_axis_lanes_tdata = '0;
      s_axis_lanes_tvalid = 1'b0;
      cfg_decim = 8'd1;
      clear_status = 1'b0;
      m_axis_ddc_tready = 1'b1;
      #2;
      n_checks++;
      if (m_axis_phase_tdata !== '0 || m_axis_phase_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_phase: got %h/%b required 0/0", m_axis_phase_tdata[63:0], m_axis_phase_tvalid);
      end
      n_checks++;
      if (m_axis_ddc_tdata !== 64'h0 || m_axis_ddc_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ddc: got %h/%b required 0/0", m_axis_ddc_tdata, m_axis_ddc_tvalid);
      end
      n_checks++;
      if ({sat_flag, drop_flag, m_axis_resync} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 000", {sat_flag, drop_flag, m_axis_resync});
      end
      tick();
      tick();
      s_axis_aresetn = 1'b1;
      tick();
      n_checks++;
      if (m_axis_ddc_tvalid !== 1'b0 || m_axis_phase_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got %b/%b required 0/0", m_axis_ddc_tvalid, m_axis_phase_tvalid);
      end
   endtask

   task automatic test_d1_basic();
      int first;
      int got;
      first = -1;
      got = 0;
      set_lanes(32'd1, 32'hFFFF_FFFF);
      for (int c = 0; c < 14; c++) begin
         s_axis_lanes_tvalid = (c < 4);
         tick();
         if (m_axis_ddc_tvalid) begin
            if (first < 0) first = c;
            got++;
            n_checks++;
            if (m_axis_ddc_tdata !== 64'hFFFF_FFF8_0000_0008) begin
               n_fail++;
               $display("FAIL d1_data: got %h required %h", m_axis_ddc_tdata, 64'hFFFF_FFF8_0000_0008);
            end
         end
      end
      s_axis_lanes_tvalid = 1'b0;
      n_checks++;
      if (first != 4) begin
         n_fail++;
         $display("FAIL d1_latency: first valid after %0d cycles, required 5", first + 1);
      end
      n_checks++;
      if (got != 4) begin
         n_fail++;
         $display("FAIL d1_count: got %0d outputs required 4", got);
      end
   endtask

   task automatic test_decim();
      logic [63:0] exp_d [4];
      int got;
      exp_d[0] = 64'h0000_0000_0000_7D00;
      exp_d[1] = 64'h0000_0000_0000_7D00;
      exp_d[2] = 64'h0000_0000_0000_3E80;
      exp_d[3] = 64'h0000_0000_0000_3E80;
      got = 0;
      do_resync(8'd4);
      set_lanes(32'd1000, 32'd0);
      for (int c = 0; c < 22; c++) begin
         s_axis_lanes_tvalid = (c < 12);
         // accumulator is inside its second frame at this point
         if (c == 8) cfg_decim = 8'd2;
         tick();
         if (m_axis_ddc_tvalid) begin
            if (got < 4) begin
               n_checks++;
               if (m_axis_ddc_tdata !== exp_d[got]) begin
                  n_fail++;
                  $display("FAIL decim_out%0d: got %h required %h", got, m_axis_ddc_tdata, exp_d[got]);
               end
            end
            got++;
         end
      end
      s_axis_lanes_tvalid = 1'b0;
      n_checks++;
      if (got != 4) begin
         n_fail++;
         $display("FAIL decim_count: got %0d outputs required 4", got);
      end
   endtask

   task automatic test_phase(input logic [31:0] poff, input logic [31:0] pinc);
      logic [63:0] exp_w;
      s_axis_phase_tdata = {poff, pinc};
      s_axis_phase_tvalid = 1'b1;
      tick();
      s_axis_phase_tvalid = 1'b0;
      n_checks++;
      if (m_axis_phase_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL phase_early: got %b required 0", m_axis_phase_tvalid);
      end
      tick();
      n_checks++;
      if (m_axis_phase_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL phase_valid: got %b required 1", m_axis_phase_tvalid);
      end
      for (int k = 0; k < 8; k++) begin
         exp_w = {poff + pinc * k, pinc << 3};
         n_checks++;
         if (m_axis_phase_tdata[64*k +: 64] !== exp_w) begin
            n_fail++;
            $display("FAIL phase_lane%0d: got %h required %h", k, m_axis_phase_tdata[64*k +: 64], exp_w);
         end
      end
      tick();
      n_checks++;
      if (m_axis_phase_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL phase_pulse: got %b required 0", m_axis_phase_tvalid);
      end
   endtask

   task automatic test_phase_back_to_back();
      s_axis_phase_tdata = {32'h1000_0000, 32'h0100_0000};
      s_axis_phase_tvalid = 1'b1;
      tick();
      s_axis_phase_tdata = {32'h2000_0000, 32'h0000_0010};
      tick();
      s_axis_phase_tvalid = 1'b0;
      n_checks++;
      if (m_axis_phase_tdata[127:64] !== 64'h1100_0000_0800_0000) begin
         n_fail++;
         $display("FAIL b2b_first: got %h required %h", m_axis_phase_tdata[127:64], 64'h1100_0000_0800_0000);
      end
      tick();
      n_checks++;
      if (m_axis_phase_tdata[127:64] !== 64'h2000_0010_0000_0080 || m_axis_phase_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second: got %h/%b required %h/1", m_axis_phase_tdata[127:64], m_axis_phase_tvalid, 64'h2000_0010_0000_0080);
      end
      tick();
   endtask

   task automatic test_saturation();
      int got;
      got = 0;
      do_resync(8'd255);
      n_checks++;
      if (sat_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_initial: got %b required 0", sat_flag);
      end
      set_lanes(32'h03FF_FFFF, 32'hFC00_0000);
      for (int c = 0; c < 267; c++) begin
         s_axis_lanes_tvalid = (c < 255);
         tick();
         if (m_axis_ddc_tvalid) begin
            got++;
            n_checks++;
            if (m_axis_ddc_tdata !== 64'h8000_0000_7FFF_FFFF) begin
               n_fail++;
               $display("FAIL sat_data: got %h required %h", m_axis_ddc_tdata, 64'h8000_0000_7FFF_FFFF);
            end
         end
      end
      s_axis_lanes_tvalid = 1'b0;
      n_checks++;
      if (got != 1 || sat_flag !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_flag_set: outputs %0d flag %b required 1/1", got, sat_flag);
      end
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      n_checks++;
      if (sat_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_clear: got %b required 0", sat_flag);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] seen [$];
      do_resync(8'd1);
      m_axis_ddc_tready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         s_axis_lanes_tvalid = (c < 3);
         set_lanes(32'(c + 1), 32'd0);
         tick();
      end
      s_axis_lanes_tvalid = 1'b0;
      n_checks++;
      if (m_axis_ddc_tvalid !== 1'b1 || m_axis_ddc_tdata !== 64'd8) begin
         n_fail++;
         $display("FAIL bp_hold: got %h/%b required %h/1", m_axis_ddc_tdata, m_axis_ddc_tvalid, 64'd8);
      end
      n_checks++;
      if (drop_flag !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_drop_flag: got %b required 1", drop_flag);
      end
      m_axis_ddc_tready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (m_axis_ddc_tvalid) seen.push_back(m_axis_ddc_tdata);
         tick();
      end
      n_checks++;
      if (seen.size() != 2) begin
         n_fail++;
         $display("FAIL bp_count: got %0d transfers required 2", seen.size());
      end else begin
         n_checks++;
         if (seen[0] !== 64'd8 || seen[1] !== 64'd16) begin
            n_fail++;
            $display("FAIL bp_order: got %h,%h required %h,%h", seen[0], seen[1], 64'd8, 64'd16);
         end
      end
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      n_checks++;
      if (drop_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drop_clear: got %b required 0", drop_flag);
      end
   endtask

   task automatic test_resync();
      int got;
      got = 0;
      do_resync(8'd4);
      for (int c = 0; c < 17; c++) begin
         s_axis_lanes_tvalid = (c < 7);
         set_lanes((c < 3) ? 32'd100 : 32'd1, 32'd0);
         resync = (c == 2);
         tick();
         if (c >= 2 && c <= 4) begin
            n_checks++;
            if (m_axis_resync !== (c == 3)) begin
               n_fail++;
               $display("FAIL resync_out_c%0d: got %b required %b", c, m_axis_resync, c == 3);
            end
         end
         if (m_axis_ddc_tvalid) begin
            got++;
            n_checks++;
            if (m_axis_ddc_tdata !== 64'd32) begin
               n_fail++;
               $display("FAIL resync_data: got %h required %h", m_axis_ddc_tdata, 64'd32);
            end
         end
      end
      resync = 1'b0;
      s_axis_lanes_tvalid = 1'b0;
      n_checks++;
      if (got != 1) begin
         n_fail++;
         $display("FAIL resync_count: got %0d outputs required 1", got);
      end
   endtask

   initial begin
      test_reset();
      test_d1_basic();
      test_decim();
      test_phase(32'h1000_0000, 32'h0100_0000);
      test_phase(32'hFF00_0000, 32'h0100_0000);
      test_phase_back_to_back();
      test_saturation();
      test_backpressure();
      test_resync();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddc_multi_combiner.md
Name: ddc_multi_combiner

Overview:
Parametrised successor of the fixed 8-lane oct-DDC glue logic. It generates per-lane DDS phase words from one {poff, pinc} command. It reduces N_LANES per-lane I/Q mixer products through a pipelined adder tree. It adds a runtime-configurable decimating accumulator with saturation and a backpressured output stream. It sits between the ddc_core lane instances and the downstream capture/DMA path.

Parameters:
N_LANES, 8, lane count; power of two, 2..16; LOG2N = log2(N_LANES).
IN_RES, 27, signed width of each per-lane I and Q product.
DECIM_BITS, 8, width of cfg_decim; maximum decimation factor 2^DECIM_BITS-1.
PH_LAT, 2, phase-generator latency in cycles; fixed and not user-tunable.

Ports:
s_axis_aclk  in  1  single clock.
s_axis_aresetn  in  1  reset, asynchronous, active-low.
s_axis_phase_tdata  in  64  [63:32] poff, [31:0] pinc.
s_axis_phase_tvalid  in  1  phase command strobe.
resync  in  1  lane/accumulator resynchronisation pulse.
m_axis_phase_tdata  out  64*N_LANES  lane k at [64k+63:64k] = {poff_k, pinc_N}.
m_axis_phase_tvalid  out  1  aligned with m_axis_phase_tdata.
m_axis_resync  out  1  resync delayed by PH_LAT; drives the lane DDS resync inputs.
s_axis_lanes_tdata  in  64*N_LANES  lane k: I at [64k+IN_RES-1:64k], Q at [64k+32+IN_RES-1:64k+32], both signed.
s_axis_lanes_tvalid  in  1  lane beat valid; no tready, input is always accepted.
cfg_decim  in  DECIM_BITS  decimation factor D; 0 is treated as 1.
clear_status  in  1  single-cycle clear of the sticky flags.
m_axis_ddc_tdata  out  64  [63:32] Q sum, [31:0] I sum, signed 32-bit.
m_axis_ddc_tvalid  out  1  output valid.
m_axis_ddc_tready  in  1  downstream ready.
sat_flag  out  1  sticky; set when any output was saturated.
drop_flag  out  1  sticky; set when a result was lost because the output FIFO was full.

Behaviour:
- Reset: all outputs are 0; accumulator, beat counter, tree valid tags, FIFO and flags are cleared; latched pinc/poff are 0.
- Phase generation:
  - On s_axis_phase_tvalid, latch pinc and poff.
  - Stage 1 registers k*pinc for k = 0..N_LANES-1 (shift-add) and pinc_N = pinc<<LOG2N.
  - Stage 2 registers poff_k = poff + k*pinc, modulo 2^32 (wrap silently).
  - m_axis_phase_tvalid and m_axis_resync equal the inputs delayed by exactly PH_LAT cycles.
  - A new command arriving mid-pipeline is processed independently; the last command wins.
- Adder tree:
  - LOG2N registered stages. Each stage sign-extends by 1 bit; tree output width is IN_RES+LOG2N.
  - A valid tag shift register travels with the data.
- resync:
  - In the same cycle, it clears every tree valid tag, the accumulator and the beat counter.
  - A lane beat presented in the same cycle as resync is discarded.
  - The FIFO contents are kept.
- Accumulator:
  - Width IN_RES+LOG2N+DECIM_BITS.
  - D is latched into d_act at reset and at each frame boundary (count wraps to 0, or resync). A cfg_decim change mid-frame takes effect at the next frame.
  - On each valid tree beat: if count == d_act-1, emit acc+sum, load acc = 0 and count = 0; otherwise acc += sum and count++.
- Emitted result: I and Q are each saturated independently to signed 32 bits (0x7FFFFFFF / 0x80000000). Any saturation sets sat_flag.
- Output:
  - 2-entry first-word-fall-through FIFO; AXI-Stream rules apply (data stable while tvalid && !tready).
  - An emit while the FIFO is full, with no pop in that cycle, drops the new result and sets drop_flag.
  - Push and pop in the same cycle on a full FIFO is accepted, not dropped.
- Latency (D=1, FIFO empty): lane beat at cycle t gives m_axis_ddc_tvalid at t+LOG2N+2.
- clear_status clears both flags. A set event in the same cycle wins over the clear.

Decomposition:
- Package ddc_multi_pkg holds: LOG2N function, phase field offsets (POFF_LSB=32, PINC_LSB=0), the 32-bit output saturation constants, and the lane I/Q field offsets (Q_LSB=32).
- Sub-module ddc_sum_tree (parameters N_LANES, IN_RES) contains the pipelined reduction with its valid tags and tag-clear input. It is instantiated twice, once for I and once for Q.

Test Plan:
- N=8, D=1, all lanes I=1, Q=-1 for 4 beats -> 4 outputs of I=8, Q=-8, first tvalid 5 cycles after the first beat.
- D=4, all lanes I=1000, Q=0, continuous input -> an output every 4th beat with I=32000, Q=0; a cfg_decim change to 2 mid-frame is applied only after the current frame completes.
- D=255, all lanes I=2^26-1, Q=-2^26 -> I=0x7FFFFFFF, Q=0x80000000, sat_flag=1; clear_status then clears it.
- D=1, tready=0, 3 beats -> first two results held in order; third dropped, drop_flag=1; after tready=1 exactly 2 transfers occur.
- Phase command poff=0x1000_0000, pinc=0x0100_0000 -> 2 cycles later lane k poff = 0x1000_0000 + k*0x0100_0000 and pinc_N = 0x0800_0000. A second case with poff=0xFF00_0000 checks wrap-around.
- D=4, resync after beat 2 plus a beat in the same cycle -> beats 1-2 and the coincident beat discarded; next output is the sum of the 4 beats after resync. m_axis_resync pulses 2 cycles after resync.
